fwd_ctrl: RTL and testbench

FWD_CTRL -- requirements
Module: fwd_ctrl

---
 rtl/fwd_ctrl_pkg.sv | 29 ++
 rtl/fwd_ctrl_match.sv | 32 +++
 rtl/fwd_ctrl.sv | 83 ++++++++
 tb/tb_fwd_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fwd_ctrl_pkg.sv
// Shared pipeline definitions: operand-source select encodings and the stage tag record.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: not applicable.
package fwd_ctrl_pkg;

    // EX operand source: register file, ALU result (y), memory data (md), delayed memory data (md_n)
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_Y   = 2'b01,
        FWD_MD  = 2'b10,
        FWD_MDN = 2'b11
    } fwd_sel_e;

    // Per-stage record of the instruction occupying that stage
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
    } tag_t;

    localparam tag_t TAG_BUBBLE = '0;

    // x0 is hardwired, so writing it never produces a forwardable value
    function automatic logic is_producer(input tag_t t);
        return t.valid && t.regwrite && (t.rd != 5'd0);
    endfunction

endpackage

// File: rtl/fwd_ctrl_match.sv
// Forwarding source select for one ID source register against the EX/MEM/WB tags.
// Latency: combinational; the caller registers the result.
// Backpressure: none; the caller masks the result on stall/flush.
//   src     : source register index
//   use_src : instruction actually reads this source
//   ex_tag, mem_tag, wb_tag : current stage tags
//   sel     : nearest-first select for the following cycle
module fwd_match
    import fwd_ctrl_pkg::*;
(
    input  logic [4:0] src,
    input  logic       use_src,
    input  tag_t       ex_tag,
    input  tag_t       mem_tag,
    input  tag_t       wb_tag,
    output fwd_sel_e   sel
);

    always_comb begin
        sel = FWD_RF;
        if (use_src && (src != 5'd0)) begin
            // A load in EX cannot supply y; skip it so the stall retry finds it in MEM as md.
            if (is_producer(ex_tag) && !ex_tag.memread && (ex_tag.rd == src))
                sel = FWD_Y;
            else if (is_producer(mem_tag) && (mem_tag.rd == src))
                sel = FWD_MD;
            else if (is_producer(wb_tag) && (wb_tag.rd == src))
                sel = FWD_MDN;
        end
    end

endmodule

// File: rtl/fwd_ctrl.sv
// Forwarding and load-use hazard control: tag pipeline EX/MEM/WB/WB2, stall, operand selects.
// Latency: afwd/bfwd registered, valid in the EX cycle of the instruction; stall combinational.
// Backpressure: stall holds PC and ID and injects an EX bubble; nothing downstream of EX stalls.
//   clk, rst        : clock, asynchronous active-high reset
//   id_*            : ID-stage instruction fields
//   flush           : squash the ID instruction
//   afwd, bfwd      : registered EX operand selects
//   stall           : load-use stall request
module fwd_ctrl
    import fwd_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] id_rd,
    input  logic       id_regwrite,
    input  logic       id_memread,
    input  logic       flush,
    output logic [1:0] afwd,
    output logic [1:0] bfwd,
    output logic       stall
);

    tag_t     ex_tag, mem_tag, wb_tag, wb2_tag;
    fwd_sel_e sel_a, sel_b;
    logic     advance;

    fwd_match u_match_a (
        .src     (id_rs1),
        .use_src (id_use_rs1),
        .ex_tag  (ex_tag),
        .mem_tag (mem_tag),
        .wb_tag  (wb_tag),
        .sel     (sel_a)
    );

    fwd_match u_match_b (
        .src     (id_rs2),
        .use_src (id_use_rs2),
        .ex_tag  (ex_tag),
        .mem_tag (mem_tag),
        .wb_tag  (wb_tag),
        .sel     (sel_b)
    );

    // Reset clears ex_tag asynchronously, which drops stall in the same cycle.
    always_comb begin
        stall = id_valid && !flush && is_producer(ex_tag) && ex_tag.memread &&
                ((id_use_rs1 && (id_rs1 == ex_tag.rd)) ||
                 (id_use_rs2 && (id_rs2 == ex_tag.rd)));
    end

    assign advance = id_valid && !stall && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_tag  <= TAG_BUBBLE;
            mem_tag <= TAG_BUBBLE;
            wb_tag  <= TAG_BUBBLE;
            wb2_tag <= TAG_BUBBLE;
            afwd    <= FWD_RF;
            bfwd    <= FWD_RF;
        end else begin
            mem_tag <= ex_tag;
            wb_tag  <= mem_tag;
            wb2_tag <= wb_tag;
            if (advance) begin
                ex_tag <= '{valid: 1'b1, rd: id_rd, regwrite: id_regwrite, memread: id_memread};
                afwd   <= sel_a;
                bfwd   <= sel_b;
            end else begin
                ex_tag <= TAG_BUBBLE;
                afwd   <= FWD_RF;
                bfwd   <= FWD_RF;
            end
        end
    end

endmodule

// File: tb/tb_fwd_ctrl.sv
// Scoreboard bench for fwd_ctrl: directed ID vectors with hand-computed selects and stall.
// Latency: expected stall checked in the issue cycle, selects one cycle later.
// Backpressure: stall cycles are reissued explicitly by the vector list.
module tb_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic       id_regwrite = 1'b0, id_memread = 1'b0, flush = 1'b0;
    logic [1:0] afwd, bfwd;
    logic       stall;

    int total = 0;
    int bad   = 0;

    logic       stall_q[$];
    logic [3:0] sel_q[$];
    string      name_q[$];
    string      prev_name = "reset_sel";

    fwd_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .flush       (flush),
        .afwd        (afwd),
        .bfwd        (bfwd),
        .stall       (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: at each negedge with pending stimulus, check this cycle's stall and the
    // selects registered for the previous cycle's instruction.
    always @(negedge clk) begin
        if (stall_q.size() > 0) begin
            logic       es;
            logic [3:0] esel;
            string      nm;
            es   = stall_q.pop_front();
            esel = sel_q.pop_front();
            nm   = name_q.pop_front();
            chk({nm, "_stall"}, {3'b0, stall}, {3'b0, es});
            chk({prev_name, "_sel"}, {afwd, bfwd}, esel);
            prev_name = nm;
        end
    end

    // One ID vector per cycle; ea/eb are the selects expected in the next cycle.
    task automatic issue(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic fl,
                         input logic es, input logic [1:0] ea, input logic [1:0] eb,
                         input string nm);
        @(posedge clk);
        #1;
        id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        id_rd = rd; id_regwrite = rw; id_memread = mr; flush = fl;
        stall_q.push_back(es);
        sel_q.push_back({ea, eb});
        name_q.push_back(nm);
    endtask

    task automatic bub3();
        for (int i = 0; i < 3; i++)
            issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, "bubble");
    endtask

    task automatic plain(input logic [4:0] rd, input logic mr);
        issue(1, 0, 0, 0, 0, rd, 1, mr, 0, 0, 2'b00, 2'b00, "producer");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #3;
        chk("reset_stall", {3'b0, stall}, 4'h0);
        chk("reset_sel", {afwd, bfwd}, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        sel_q.push_back(4'h0);

        // ALU x5 then dependent op: y forward
        plain(5, 0);
        issue(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 2'b01, 2'b00, "dep_x5");
        bub3();

        // Distance 1/2/3 to producer x7 on rs2
        plain(7, 0); plain(10, 0);
        issue(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 2'b00, 2'b10, "gap1");
        bub3();
        plain(7, 0); plain(10, 0); plain(11, 0);
        issue(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 2'b00, 2'b11, "gap2");
        bub3();
        plain(7, 0); plain(10, 0); plain(11, 0); plain(12, 0);
        issue(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, "gap3");
        bub3();

        // Load-use: one stall cycle, then md on retry
        plain(3, 1);
        issue(1, 3, 1, 0, 0, 4, 1, 0, 0, 1, 2'b00, 2'b00, "load_use_stall");
        issue(1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 2'b10, 2'b00, "load_use_retry");
        issue(1, 4, 1, 3, 1, 0, 0, 0, 0, 0, 2'b01, 2'b11, "after_retry");
        bub3();

        // x0 never forwards; flushed consumer becomes a bubble
        plain(0, 0);
        issue(1, 0, 1, 0, 0, 8, 1, 0, 0, 0, 2'b00, 2'b00, "x0_no_fwd");
        plain(4, 0);
        issue(1, 4, 1, 4, 1, 12, 1, 0, 1, 0, 2'b00, 2'b00, "flush_consumer");
        issue(1, 12, 1, 8, 1, 13, 0, 0, 0, 0, 2'b00, 2'b11, "after_flush");
        bub3();

        // Flush beats a load-use stall
        plain(6, 1);
        issue(1, 6, 1, 0, 0, 14, 1, 0, 1, 0, 2'b00, 2'b00, "flush_beats_stall");
        issue(1, 14, 1, 6, 1, 0, 0, 0, 0, 0, 2'b00, 2'b10, "after_flush_stall");
        bub3();

        // Two producers of x9: nearest wins, rs1==rs2 identical
        plain(9, 0); plain(9, 0);
        issue(1, 9, 1, 9, 1, 0, 0, 0, 0, 0, 2'b01, 2'b01, "nearest_wins");
        issue(1, 9, 0, 9, 1, 0, 0, 0, 0, 0, 2'b00, 2'b10, "unused_src");
        issue(0, 9, 1, 9, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, "id_invalid");
        bub3();

        @(posedge clk);
        #1;
        id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_regwrite = 0; id_memread = 0;
        @(negedge clk);
        #1;
        chk("drain", stall_q.size() == 0 ? 4'h0 : 4'h1, 4'h0);
        sel_q.delete();

        // Reset asserted during a load-use stall
        @(posedge clk); #1;
        id_valid = 1; id_rd = 2; id_regwrite = 1; id_memread = 0;
        @(posedge clk); #1;
        id_rs1 = 2; id_use_rs1 = 1; id_rd = 3; id_memread = 1;
        @(posedge clk); #1;
        id_rs1 = 3; id_use_rs1 = 1; id_rs2 = 2; id_use_rs2 = 1; id_rd = 5; id_memread = 0;
        #2;
        chk("pre_rst_stall", {3'b0, stall}, 4'h1);
        chk("pre_rst_afwd", {2'b0, afwd}, 4'h1);
        rst = 1'b1;
        #1;
        chk("rst_stall", {3'b0, stall}, 4'h0);
        chk("rst_sel", {afwd, bfwd}, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_stall", {3'b0, stall}, 4'h0);
        chk("post_rst_sel", {afwd, bfwd}, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
